// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, operand selects, immediate formats
// and the ALU op codes consumed by execute.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;
  localparam logic       B_SEL_RS2  = 1'b0;
  localparam logic       B_SEL_IMM  = 1'b1;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_SLL     = 4'd2;
  localparam logic [3:0] ALU_SLT     = 4'd3;
  localparam logic [3:0] ALU_SLTU    = 4'd4;
  localparam logic [3:0] ALU_XOR     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_OR      = 4'd8;
  localparam logic [3:0] ALU_AND     = 4'd9;
  localparam logic [3:0] ALU_NOP     = 4'd14;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       rd_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{alu_sel: ALU_NOP, a_sel: 2'd0, b_sel: 1'b0, rd_we: 1'b0,
                                   mem_rd: 1'b0, mem_wr: 1'b0, branch: 1'b0, jump: 1'b0,
                                   illegal: 1'b0};

  // Base-encoding (funct7 = 0) register/immediate op for a funct3 value.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; opcode bits are not needed so only [31:7] enter.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [31:7]           i_instr,
  input  imm_type_e             i_imm_type,
  output logic [DATA_WIDTH-1:0] o_imm
);

  logic [31:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (i_imm_type)
      ImmI: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      ImmS: w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      ImmB: w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
      ImmU: w_imm = {i_instr[31:12], 12'b0};
      ImmJ: w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign o_imm = DATA_WIDTH'($signed(w_imm));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready input, one-deep output register feeding execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_alu_sel,
  output logic [1:0]            out_a_sel,
  output logic                  out_b_sel,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic                  out_illegal,
  output logic [DATA_WIDTH-1:0] out_pc
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic                  w_legal;
  logic                  w_in_fire;
  ctrl_t                 w_ctrl;
  imm_type_e             w_imm_type;
  logic [DATA_WIDTH-1:0] w_imm;

  logic                  r_valid;
  ctrl_t                 r_ctrl;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [4:0]            r_rd;
  logic [DATA_WIDTH-1:0] r_pc;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  always_comb begin
    w_ctrl         = '0;
    w_ctrl.alu_sel = ALU_ADD;
    w_imm_type     = ImmI;
    w_legal        = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_ctrl.rd_we = 1'b1;
        if (w_funct7 == F7_BASE) w_ctrl.alu_sel = alu_from_funct3(w_funct3);
        else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD_SUB) w_ctrl.alu_sel = ALU_SUB;
        else if (w_funct7 == F7_ALT && w_funct3 == F3_SRL_SRA) w_ctrl.alu_sel = ALU_SRA;
        else w_legal = 1'b0;
      end
      OPC_OP_IMM: begin
        w_ctrl.rd_we   = 1'b1;
        w_ctrl.b_sel   = B_SEL_IMM;
        w_ctrl.alu_sel = alu_from_funct3(w_funct3);
        // Shift-immediates reuse imm[11:5] as funct7.
        if (w_funct3 == F3_SLL && w_funct7 != F7_BASE) w_legal = 1'b0;
        if (w_funct3 == F3_SRL_SRA) begin
          if (w_funct7 == F7_ALT) w_ctrl.alu_sel = ALU_SRA;
          else if (w_funct7 != F7_BASE) w_legal = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_ctrl.rd_we = 1'b1;
        w_ctrl.a_sel = (w_opcode == OPC_LUI) ? A_SEL_ZERO : A_SEL_PC;
        w_ctrl.b_sel = B_SEL_IMM;
        w_imm_type   = ImmU;
      end
      OPC_LOAD: begin
        w_ctrl.rd_we  = 1'b1;
        w_ctrl.mem_rd = 1'b1;
        w_ctrl.b_sel  = B_SEL_IMM;
        w_legal       = w_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OPC_STORE: begin
        w_ctrl.mem_wr = 1'b1;
        w_ctrl.b_sel  = B_SEL_IMM;
        w_imm_type    = ImmS;
        w_legal       = (w_funct3 <= 3'd2);
      end
      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_imm_type    = ImmB;
        case (w_funct3)
          F3_BEQ, F3_BNE:   w_ctrl.alu_sel = ALU_SUB;
          F3_BLT, F3_BGE:   w_ctrl.alu_sel = ALU_SLT;
          F3_BLTU, F3_BGEU: w_ctrl.alu_sel = ALU_SLTU;
          default:          w_legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        w_ctrl.rd_we = 1'b1;
        w_ctrl.jump  = 1'b1;
        w_ctrl.a_sel = A_SEL_PC;
        w_ctrl.b_sel = B_SEL_IMM;
        w_imm_type   = ImmJ;
      end
      OPC_JALR: begin
        w_ctrl.rd_we = 1'b1;
        w_ctrl.jump  = 1'b1;
        w_ctrl.b_sel = B_SEL_IMM;
        w_legal      = (w_funct3 == 3'd0);
      end
      OPC_MISC_MEM, OPC_SYSTEM: w_ctrl.alu_sel = ALU_NOP;
      default: w_legal = 1'b0;
    endcase
    // Illegal words become an inert bundle so execute never acts on them.
    if (!w_legal) begin
      w_ctrl         = '0;
      w_ctrl.alu_sel = ALU_INVALID;
      w_ctrl.illegal = 1'b1;
    end
    if (in_instr[11:7] == 5'd0) w_ctrl.rd_we = 1'b0;
  end

  decode_stage_imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .i_instr   (in_instr[31:7]),
    .i_imm_type(w_imm_type),
    .o_imm     (w_imm)
  );

  assign in_ready  = !r_valid || out_ready;
  assign w_in_fire = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_RESET;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_pc    <= RESET_PC;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_imm   <= w_imm;
      r_rs1   <= in_instr[19:15];
      r_rs2   <= in_instr[24:20];
      r_rd    <= in_instr[11:7];
      r_pc    <= in_pc;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_alu_sel = r_ctrl.alu_sel;
  assign out_a_sel   = r_ctrl.a_sel;
  assign out_b_sel   = r_ctrl.b_sel;
  assign out_rd_we   = r_ctrl.rd_we;
  assign out_mem_rd  = r_ctrl.mem_rd;
  assign out_mem_wr  = r_ctrl.mem_wr;
  assign out_branch  = r_ctrl.branch;
  assign out_jump    = r_ctrl.jump;
  assign out_illegal = r_ctrl.illegal;
  assign out_imm     = r_imm;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_pc      = r_pc;

endmodule
